// File: rtl/vec_cat_stream.sv
// vec_cat_stream: repacks densely packed vectors from a bus-word stream into one whole vector per handshake,
// tagged reference/compare with per-class IDs and a batch-last flag.
module vec_cat_stream #(
  parameter int BUS_WIDTH    = 96,
  parameter int VECTOR_WIDTH = 128,
  parameter int VEC_ID_WIDTH = 8,
  parameter int DEF_REF_NO   = 8,
  parameter int DEF_CMP_NO   = 128
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [BUS_WIDTH-1:0]    i_Vector,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  output logic [VECTOR_WIDTH-1:0] o_Vector,
  output logic [VEC_ID_WIDTH-1:0] o_VecID,
  output logic                    o_IsRef,
  output logic                    o_Last,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  input  logic [VEC_ID_WIDTH-1:0] i_RefNo,
  input  logic [VEC_ID_WIDTH-1:0] i_CmpNo,
  input  logic                    i_CfgValid,
  output logic                    o_CfgAck
);
  localparam int AW = VECTOR_WIDTH + BUS_WIDTH;
  localparam int FW = $clog2(AW + 1);
  localparam int CW = VEC_ID_WIDTH + 1;
  localparam logic [FW-1:0] VWF = FW'(VECTOR_WIDTH);
  localparam logic [FW-1:0] BWF = FW'(BUS_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, CFGBLOCK} state_t;

  state_t                  state, nxt;
  logic [AW-1:0]           acc, acc_n, sh;
  logic [FW-1:0]           fill, fill_s, fill_n;
  logic [CW-1:0]           cnt, total;
  logic [VEC_ID_WIDTH-1:0] ref_no, cmp_no;
  logic                    fire, accept, last, is_ref, cfg_take;

  assign total    = {1'b0, ref_no} + {1'b0, cmp_no};
  assign is_ref   = cnt < {1'b0, ref_no};
  assign last     = cnt == total - CW'(1);
  assign cfg_take = state == IDLE && i_CfgValid;
  assign o_Valid  = state == RUN && fill >= VWF;
  assign fire     = o_Valid && i_Ready;
  assign fill_s   = fire ? fill - VWF : fill;
  // Accept only while the post-shift fill is below one vector, so a word always fits in acc.
  assign o_Ready  = rstn && state != CFGBLOCK && !cfg_take && total != '0 && fill_s < VWF;
  assign accept   = i_Valid && o_Ready;
  // Bits at and above fill are always zero, so the new word can simply be OR-ed in.
  assign sh       = fire ? acc >> VECTOR_WIDTH : acc;
  assign acc_n    = sh | (accept ? {{VECTOR_WIDTH{1'b0}}, i_Vector} << fill_s : '0);
  assign fill_n   = fill_s + (accept ? BWF : '0);

  assign o_Vector = acc[VECTOR_WIDTH-1:0];
  assign o_IsRef  = o_Valid && is_ref;
  assign o_Last   = o_Valid && last;
  assign o_VecID  = !o_Valid ? '0 : is_ref ? cnt[VEC_ID_WIDTH-1:0] : cnt[VEC_ID_WIDTH-1:0] - ref_no;
  assign o_CfgAck = state == CFGBLOCK;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cfg_take ? CFGBLOCK : accept ? RUN : IDLE;
      RUN:     nxt = fire && last ? IDLE : RUN;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      acc    <= '0;
      fill   <= '0;
      cnt    <= '0;
      ref_no <= VEC_ID_WIDTH'(DEF_REF_NO);
      cmp_no <= VEC_ID_WIDTH'(DEF_CMP_NO);
    end else begin
      state <= nxt;
      if (cfg_take) begin
        ref_no <= i_RefNo;
        cmp_no <= i_CmpNo;
      end
      // Closing a batch drops the final word's residue and any word arriving alongside it.
      if (fire && last) begin
        acc  <= '0;
        fill <= '0;
        cnt  <= '0;
      end else begin
        acc  <= acc_n;
        fill <= fill_n;
        cnt  <= cnt + CW'(fire);
      end
    end
  end
endmodule
